// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and op-class helpers.
package mdu_ctrl_pkg;

  localparam int MDU_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU connection: operation request from the pipeline, stall/result back to it.
interface mdu_ctrl_if #(parameter int DATA_W = 32) ();
  import mdu_ctrl_pkg::*;

  logic              start;
  mdu_op_e           op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              done;
  logic              hilo_we;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall, busy, done, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall, busy, done, hilo_we, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_ctrl_div_radix2_step.sv
// One restoring-division step: shift {rem,quo} left by one and subtract the divisor if it fits.
module div_radix2_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem < divisor always holds, so the top bit of diff is a clean borrow flag
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[DATA_W]) begin
      rem_next = diff[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for EX: registered multiplier, iterated restoring
// divider, HI/LO commit strobe and flush abort.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; operands latched on acceptance
//   ST_MUL  | product settling for MUL_LAT cycles
//   ST_DIV  | one restoring step per cycle, count 0..DATA_W-1
//   ST_DONE | one-cycle result cycle, done/hilo_we asserted
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DATA_W  = MDU_DATA_W,
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  mdu_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W);

  mdu_state_e          state;
  logic [CNT_W-1:0]    count;
  mdu_op_e             op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   dvsr_q;
  logic                neg_quo;
  logic                neg_rem;
  logic                done_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                sgn_in;
  logic                sgn_mul;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  assign sgn_in  = op_is_signed(bus.op);
  assign sgn_mul = (op_q == OP_MULT);

  // Sign/zero extension to full width makes the low 2*DATA_W bits of one unsigned multiply
  // correct for both MULT and MULTU.
  assign mul_a   = {{DATA_W{sgn_mul & a_q[DATA_W-1]}}, a_q};
  assign mul_b   = {{DATA_W{sgn_mul & b_q[DATA_W-1]}}, b_q};
  assign product = mul_a * mul_b;

  div_radix2_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign quo_fix = neg_quo ? -quo_next : quo_next;
  assign rem_fix = neg_rem ? -rem_next : rem_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      count   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              op_q  <= bus.op;
              a_q   <= bus.src_a;
              b_q   <= bus.src_b;
              count <= '0;
              if (!op_is_div(bus.op)) begin
                state <= ST_MUL;
              end else if (bus.src_b == '0) begin
                hi_q   <= bus.src_a;
                lo_q   <= '1;
                done_q <= 1'b1;
                state  <= ST_DONE;
              end else begin
                rem_q   <= '0;
                quo_q   <= mag(bus.src_a, sgn_in);
                dvsr_q  <= mag(bus.src_b, sgn_in);
                neg_quo <= sgn_in & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                neg_rem <= sgn_in & bus.src_a[DATA_W-1];
                state   <= ST_DIV;
              end
            end
          end
          ST_MUL: begin
            if (count == CNT_W'(MUL_LAT - 1)) begin
              hi_q   <= product[2*DATA_W-1:DATA_W];
              lo_q   <= product[DATA_W-1:0];
              done_q <= 1'b1;
              count  <= '0;
              state  <= ST_DONE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          ST_DIV: begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (count == CNT_W'(DATA_W - 1)) begin
              hi_q   <= rem_fix;
              lo_q   <= quo_fix;
              done_q <= 1'b1;
              count  <= '0;
              state  <= ST_DONE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.stall   = bus.start & ~done_q;
  assign bus.hilo_we = done_q & ~bus.flush;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule
